aui_lane_prbs_checker: RTL and testbench

//  Parametrised per-lane PRBS31 checker for the AUI receive side: NUM_LANES lanes of LANE_W bits
//  per valid cycle. Each lane runs a self-synchronising PRBS31 compare, a HUNT/LOCKED lock FSM,
//  and saturating bit/sync error counters. It also checks frame-sync strobe periodicity.
//  It sits after lane demux, in parallel with aui_checker, as the generalised bit-error monitor.

---
 rtl/aui_lane_prbs_checker.sv | 191 +++++++++++++++++++
 tb/tb_aui_lane_prbs_checker.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aui_lane_prbs_checker.sv
// Per-lane PRBS31 (x^31+x^28+1) bit-error checker with HUNT/LOCKED lock tracking,
// saturating bit/sync error counters and frame-sync periodicity monitoring.
//
// state  | meaning
// HUNT   | searching: counting consecutive clean words towards lock
// LOCKED | locked: counting errored words per window, accumulating bit errors
module aui_lane_prbs_checker #(
    parameter int NUM_LANES   = 16,
    parameter int LANE_W      = 64,
    parameter int CNT_W       = 32,
    parameter int LOCK_WORDS  = 64,
    parameter int WINDOW      = 1024,
    parameter int UNLOCK_ERRS = 16,
    parameter int FRAME_WORDS = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [NUM_LANES*LANE_W-1:0] i_lane_data,
    input  logic [NUM_LANES-1:0]       i_sync,
    input  logic                       i_clear_cnt,
    output logic [NUM_LANES-1:0]       o_lock,
    output logic [NUM_LANES-1:0]       o_frame_lock,
    output logic [NUM_LANES-1:0]       o_err_pulse,
    output logic [NUM_LANES*CNT_W-1:0] o_err_cnt,
    output logic [NUM_LANES*CNT_W-1:0] o_sync_err_cnt
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam int GW = $clog2(LOCK_WORDS + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);
    localparam int PW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int EW = $clog2(LANE_W + 1);

    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_WORDS - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERRS - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_WORDS - 1);

    genvar k;
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [LANE_W-1:0] rx_word;
        logic [LANE_W-1:0] exp_word;
        logic [LANE_W-1:0] diff;
        logic [30:0]       hist;
        logic [30:0]       pr;
        logic              pr_bit;
        logic              seeded;
        logic [0:0]        state;
        logic [GW-1:0]     good_cnt;
        logic [WW-1:0]     win_cnt;
        logic [BW-1:0]     bad_cnt;
        logic [EW-1:0]     word_err;
        logic              word_bad;
        logic              err_pulse;
        logic [EW-1:0]     err_inc;
        logic [CNT_W-1:0]  err_cnt;
        logic [CNT_W-1:0]  err_base;
        logic [CNT_W:0]    err_sum;
        logic [CNT_W-1:0]  err_next;
        logic              phased;
        logic              frame_lock;
        logic [PW-1:0]     pos;
        logic              sync_inc;
        logic [CNT_W-1:0]  sync_cnt;
        logic [CNT_W-1:0]  sync_base;
        logic [CNT_W:0]    sync_sum;
        logic [CNT_W-1:0]  sync_next;

        assign rx_word = i_lane_data[k*LANE_W +: LANE_W];

        // Whole expected word is extended from the previous word's last 31 bits only,
        // so errors inside the current word never feed back into its own prediction.
        always_comb begin
            pr       = hist;
            pr_bit   = 1'b0;
            exp_word = '0;
            for (int j = LANE_W - 1; j >= 0; j--) begin
                pr_bit      = pr[27] ^ pr[30];
                exp_word[j] = pr_bit;
                pr          = {pr[29:0], pr_bit};
            end
        end

        assign diff = exp_word ^ rx_word;

        always_comb begin
            word_err = '0;
            for (int j = 0; j < LANE_W; j++) begin
                word_err = word_err + {{(EW-1){1'b0}}, diff[j]};
            end
        end

        assign word_bad = (word_err != '0) || (rx_word[30:0] == 31'd0);

        assign err_inc   = (i_valid && seeded && state == LOCKED && word_bad) ? word_err : '0;
        assign err_base  = i_clear_cnt ? '0 : err_cnt;
        assign err_sum   = {1'b0, err_base} + {{(CNT_W+1-EW){1'b0}}, err_inc};
        assign err_next  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

        assign sync_inc  = i_valid && phased &&
                           ((i_sync[k] && pos != POS_LAST) || (!i_sync[k] && pos == POS_LAST));
        assign sync_base = i_clear_cnt ? '0 : sync_cnt;
        assign sync_sum  = {1'b0, sync_base} + {{CNT_W{1'b0}}, sync_inc};
        assign sync_next = sync_sum[CNT_W] ? '1 : sync_sum[CNT_W-1:0];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hist       <= '0;
                seeded     <= 1'b0;
                state      <= HUNT;
                good_cnt   <= '0;
                win_cnt    <= '0;
                bad_cnt    <= '0;
                err_pulse  <= 1'b0;
                err_cnt    <= '0;
                phased     <= 1'b0;
                frame_lock <= 1'b0;
                pos        <= '0;
                sync_cnt   <= '0;
            end else begin
                err_pulse <= 1'b0;
                err_cnt   <= err_next;
                sync_cnt  <= sync_next;
                if (i_valid) begin
                    hist   <= rx_word[30:0];
                    seeded <= 1'b1;
                    if (seeded) begin
                        case (state)
                            HUNT: begin
                                if (word_bad) begin
                                    good_cnt <= '0;
                                end else if (good_cnt == GOOD_LAST) begin
                                    state    <= LOCKED;
                                    good_cnt <= '0;
                                    win_cnt  <= '0;
                                    bad_cnt  <= '0;
                                end else begin
                                    good_cnt <= good_cnt + 1'b1;
                                end
                            end
                            default: begin
                                err_pulse <= word_bad;
                                // loss of lock wins over a window wrap on the same word
                                if (word_bad && bad_cnt == BAD_LAST) begin
                                    state    <= HUNT;
                                    good_cnt <= '0;
                                    win_cnt  <= '0;
                                    bad_cnt  <= '0;
                                end else if (win_cnt == WIN_LAST) begin
                                    win_cnt <= '0;
                                    bad_cnt <= '0;
                                end else begin
                                    win_cnt <= win_cnt + 1'b1;
                                    if (word_bad) bad_cnt <= bad_cnt + 1'b1;
                                end
                            end
                        endcase
                    end

                    // pos holds (words since last accepted sync) - 1
                    if (!phased) begin
                        if (i_sync[k]) begin
                            phased <= 1'b1;
                            pos    <= '0;
                        end
                    end else if (i_sync[k]) begin
                        pos <= '0;
                        frame_lock <= (pos == POS_LAST);
                    end else if (pos == POS_LAST) begin
                        phased     <= 1'b0;
                        frame_lock <= 1'b0;
                        pos        <= '0;
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end
            end
        end

        assign o_lock[k]                        = (state == LOCKED);
        assign o_frame_lock[k]                  = frame_lock;
        assign o_err_pulse[k]                   = err_pulse;
        assign o_err_cnt[k*CNT_W +: CNT_W]      = err_cnt;
        assign o_sync_err_cnt[k*CNT_W +: CNT_W] = sync_cnt;
    end

endmodule

// File: tb/tb_aui_lane_prbs_checker.sv
// Self-checking bench for aui_lane_prbs_checker: directed scenarios plus randomized
// traffic compared against a word-level behavioural model.
module tb_aui_lane_prbs_checker;

    localparam int NL    = 16;
    localparam int LW    = 64;
    localparam int CW    = 32;
    localparam int LOCKW = 64;
    localparam int WIN   = 1024;
    localparam int UNL   = 16;
    localparam int FW    = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_valid = 1'b0;
    logic [NL*LW-1:0]  i_lane_data = '0;
    logic [NL-1:0]     i_sync = '0;
    logic              i_clear_cnt = 1'b0;
    logic [NL-1:0]     o_lock;
    logic [NL-1:0]     o_frame_lock;
    logic [NL-1:0]     o_err_pulse;
    logic [NL*CW-1:0]  o_err_cnt;
    logic [NL*CW-1:0]  o_sync_err_cnt;

    always #5 clk = ~clk;

    aui_lane_prbs_checker #(
        .NUM_LANES(NL), .LANE_W(LW), .CNT_W(CW), .LOCK_WORDS(LOCKW),
        .WINDOW(WIN), .UNLOCK_ERRS(UNL), .FRAME_WORDS(FW)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_lane_data(i_lane_data),
        .i_sync(i_sync), .i_clear_cnt(i_clear_cnt), .o_lock(o_lock),
        .o_frame_lock(o_frame_lock), .o_err_pulse(o_err_pulse),
        .o_err_cnt(o_err_cnt), .o_sync_err_cnt(o_sync_err_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [30:0]   tx_st [NL];

    // behavioural model state
    logic [30:0]   m_prev [NL];
    bit            m_seeded [NL];
    bit            m_locked [NL];
    int            m_good [NL];
    int            m_win [NL];
    int            m_bad [NL];
    logic [CW-1:0] m_err [NL];
    bit            m_pulse [NL];
    int            m_vidx [NL];
    int            m_last [NL];
    bit            m_phased [NL];
    bit            m_fl [NL];
    logic [CW-1:0] m_serr [NL];

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            m_prev[l] = '0; m_seeded[l] = 0; m_locked[l] = 0; m_good[l] = 0;
            m_win[l] = 0; m_bad[l] = 0; m_err[l] = '0; m_pulse[l] = 0;
            m_vidx[l] = 0; m_last[l] = 0; m_phased[l] = 0; m_fl[l] = 0; m_serr[l] = '0;
        end
    endtask

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input int b);
        logic [CW:0] t;
        t = {1'b0, a} + 33'(b);
        return t[CW] ? '1 : t[CW-1:0];
    endfunction

    task automatic model_update(input logic v, input logic [NL*LW-1:0] d,
                                input logic [NL-1:0] s, input logic clr);
        logic [LW-1:0] w;
        logic [LW-1:0] expw;
        logic          seq [LW+31];
        int            e;
        bit            bad;
        for (int l = 0; l < NL; l++) begin
            m_pulse[l] = 0;
            if (clr) begin
                m_err[l]  = '0;
                m_serr[l] = '0;
            end
            if (v) begin
                w = d[l*LW +: LW];
                if (m_seeded[l]) begin
                    // seq[] in transmission order: 31 known bits, then the recurrence
                    for (int i = 0; i < 31; i++) seq[i] = m_prev[l][30-i];
                    for (int i = 31; i < LW + 31; i++) begin
                        seq[i] = seq[i-28] ^ seq[i-31];
                        expw[LW+30-i] = seq[i];
                    end
                    e   = $countones(expw ^ w);
                    bad = (e != 0) || (w[30:0] == 31'd0);
                    if (!m_locked[l]) begin
                        if (bad) m_good[l] = 0;
                        else begin
                            m_good[l]++;
                            if (m_good[l] == LOCKW) begin
                                m_locked[l] = 1; m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0;
                            end
                        end
                    end else begin
                        m_win[l]++;
                        if (bad) begin
                            m_bad[l]++;
                            m_pulse[l] = 1;
                            m_err[l] = sat_add(m_err[l], e);
                        end
                        if (m_bad[l] == UNL) begin
                            m_locked[l] = 0; m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0;
                        end else if (m_win[l] == WIN) begin
                            m_win[l] = 0; m_bad[l] = 0;
                        end
                    end
                end
                m_prev[l]   = w[30:0];
                m_seeded[l] = 1;
                m_vidx[l]++;
                if (m_phased[l]) begin
                    if (s[l]) begin
                        if (m_vidx[l] - m_last[l] == FW) m_fl[l] = 1;
                        else begin
                            m_serr[l] = sat_add(m_serr[l], 1);
                            m_fl[l] = 0;
                        end
                        m_last[l] = m_vidx[l];
                    end else if (m_vidx[l] - m_last[l] == FW) begin
                        m_serr[l] = sat_add(m_serr[l], 1);
                        m_fl[l] = 0;
                        m_phased[l] = 0;
                    end
                end else if (s[l]) begin
                    m_phased[l] = 1;
                    m_last[l] = m_vidx[l];
                end
            end
        end
    endtask

    task automatic gen_clean(output logic [NL*LW-1:0] d);
        logic b;
        d = '0;
        for (int l = 0; l < NL; l++) begin
            for (int j = LW - 1; j >= 0; j--) begin
                b = tx_st[l][27] ^ tx_st[l][30];
                d[l*LW + j] = b;
                tx_st[l] = {tx_st[l][29:0], b};
            end
        end
    endtask

    task automatic gen_garbage(output logic [NL*LW-1:0] d);
        for (int i = 0; i < NL*LW/32; i++) d[i*32 +: 32] = $urandom;
    endtask

    task automatic step(input logic v, input logic [NL*LW-1:0] d,
                        input logic [NL-1:0] s, input logic clr);
        @(negedge clk);
        i_valid = v; i_lane_data = d; i_sync = s; i_clear_cnt = clr;
        @(posedge clk);
        model_update(v, d, s, clr);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0; i_sync = '0; i_clear_cnt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge clk); #1;
        checks++; if (o_lock !== '0) begin errors++; $display("FAIL reset_lock got=%h exp=0", o_lock); end
        checks++; if (o_frame_lock !== '0) begin errors++; $display("FAIL reset_frame_lock got=%h exp=0", o_frame_lock); end
        checks++; if (o_err_pulse !== '0) begin errors++; $display("FAIL reset_err_pulse got=%h exp=0", o_err_pulse); end
        checks++; if (o_err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got=%h exp=0", o_err_cnt); end
        checks++; if (o_sync_err_cnt !== '0) begin errors++; $display("FAIL reset_sync_err_cnt got=%h exp=0", o_sync_err_cnt); end
    endtask

    task automatic test_lock();
        logic [NL*LW-1:0] d;
        logic [NL-1:0]    exp;
        for (int w = 1; w <= 65; w++) begin
            gen_clean(d);
            step(1'b1, d, '0, 1'b0);
            exp = (w == 65) ? '1 : '0;
            checks++;
            if (o_lock !== exp) begin errors++; $display("FAIL lock_word%0d got=%h exp=%h", w, o_lock, exp); end
        end
        checks++; if (o_err_cnt !== '0) begin errors++; $display("FAIL lock_err_cnt got=%h exp=0", o_err_cnt); end
        checks++; if (o_err_pulse !== '0) begin errors++; $display("FAIL lock_err_pulse got=%h exp=0", o_err_pulse); end
    endtask

    task automatic test_bit_error();
        logic [NL*LW-1:0] d;
        gen_clean(d);
        d[5*LW+63] = ~d[5*LW+63];
        d[5*LW+50] = ~d[5*LW+50];
        d[5*LW+40] = ~d[5*LW+40];
        step(1'b1, d, '0, 1'b0);
        checks++; if (o_err_pulse !== 16'h0020) begin errors++; $display("FAIL biterr_pulse got=%h exp=0020", o_err_pulse); end
        checks++; if (o_err_cnt[5*CW +: CW] !== 32'd3) begin errors++; $display("FAIL biterr_cnt5 got=%0d exp=3", o_err_cnt[5*CW +: CW]); end
        checks++; if (o_lock !== '1) begin errors++; $display("FAIL biterr_lock got=%h exp=ffff", o_lock); end
        gen_clean(d);
        step(1'b1, d, '0, 1'b0);
        checks++; if (o_err_pulse !== '0) begin errors++; $display("FAIL biterr_next_pulse got=%h exp=0", o_err_pulse); end
        checks++; if (o_err_cnt[5*CW +: CW] !== 32'd3) begin errors++; $display("FAIL biterr_next_cnt5 got=%0d exp=3", o_err_cnt[5*CW +: CW]); end
    endtask

    task automatic test_lane_lockup();
        logic [NL*LW-1:0] d;
        logic [NL-1:0]    exp;
        for (int z = 1; z <= 16; z++) begin
            gen_clean(d);
            d[2*LW +: LW] = '0;
            step(1'b1, d, '0, 1'b0);
            exp = (z < 16) ? '1 : 16'hFFFB;
            checks++;
            if (o_lock !== exp) begin errors++; $display("FAIL lockup_lock_z%0d got=%h exp=%h", z, o_lock, exp); end
            checks++;
            if (o_err_pulse !== 16'h0004) begin errors++; $display("FAIL lockup_pulse_z%0d got=%h exp=0004", z, o_err_pulse); end
        end
        checks++;
        if (o_err_cnt[2*CW +: CW] !== m_err[2]) begin
            errors++; $display("FAIL lockup_cnt2 got=%0d exp=%0d", o_err_cnt[2*CW +: CW], m_err[2]);
        end
    endtask

    task automatic test_valid_gaps();
        logic [NL*LW-1:0] d;
        logic [NL-1:0]    exp;
        logic             v;
        int               vcount = 0;
        apply_reset();
        for (int cyc = 0; cyc < 400 && vcount < 70; cyc++) begin
            v = 1'($urandom_range(0, 1));
            if (v) gen_clean(d); else gen_garbage(d);
            step(v, d, '0, 1'b0);
            if (v) vcount++;
            exp = (vcount >= 65) ? '1 : '0;
            checks++;
            if (o_lock !== exp) begin errors++; $display("FAIL gaps_lock_v%0d got=%h exp=%h", vcount, o_lock, exp); end
            checks++;
            if (o_err_pulse !== '0) begin errors++; $display("FAIL gaps_pulse got=%h exp=0", o_err_pulse); end
        end
        checks++;
        if (vcount < 70) begin errors++; $display("FAIL gaps_budget got=%0d exp=70 valid words", vcount); end
    endtask

    task automatic test_sync();
        logic [NL*LW-1:0] d;
        logic [NL-1:0]    s;
        logic [NL-1:0]    exp_fl;
        for (int t = 0; t <= 1545; t++) begin
            gen_clean(d);
            s = '0;
            if (t == 10 || t == 266 || t == 522 || t == 777 || t == 1033 || t == 1289) s[7] = 1'b1;
            step(1'b1, d, s, 1'b0);
            for (int l = 0; l < NL; l++) exp_fl[l] = m_fl[l];
            checks++;
            if (o_frame_lock !== exp_fl) begin errors++; $display("FAIL sync_fl_t%0d got=%h exp=%h", t, o_frame_lock, exp_fl); end
            checks++;
            if (o_sync_err_cnt[7*CW +: CW] !== m_serr[7]) begin
                errors++; $display("FAIL sync_cnt7_t%0d got=%0d exp=%0d", t, o_sync_err_cnt[7*CW +: CW], m_serr[7]);
            end
            if (t == 266) begin
                checks++; if (o_frame_lock[7] !== 1'b1) begin errors++; $display("FAIL sync_first_lock got=%b exp=1", o_frame_lock[7]); end
            end
            if (t == 777) begin
                checks++; if (o_sync_err_cnt[7*CW +: CW] !== 32'd1) begin errors++; $display("FAIL sync_early_cnt got=%0d exp=1", o_sync_err_cnt[7*CW +: CW]); end
                checks++; if (o_frame_lock[7] !== 1'b0) begin errors++; $display("FAIL sync_early_fl got=%b exp=0", o_frame_lock[7]); end
            end
            if (t == 1289) begin
                checks++; if (o_frame_lock[7] !== 1'b1) begin errors++; $display("FAIL sync_relock got=%b exp=1", o_frame_lock[7]); end
                checks++; if (o_sync_err_cnt[7*CW +: CW] !== 32'd1) begin errors++; $display("FAIL sync_relock_cnt got=%0d exp=1", o_sync_err_cnt[7*CW +: CW]); end
            end
            if (t == 1545) begin
                checks++; if (o_sync_err_cnt[7*CW +: CW] !== 32'd2) begin errors++; $display("FAIL sync_missing_cnt got=%0d exp=2", o_sync_err_cnt[7*CW +: CW]); end
                checks++; if (o_frame_lock[7] !== 1'b0) begin errors++; $display("FAIL sync_missing_fl got=%b exp=0", o_frame_lock[7]); end
            end
        end
    endtask

    task automatic test_reset_clear();
        logic [NL*LW-1:0] d;
        for (int i = 0; i < 20; i++) begin
            gen_clean(d);
            step(1'b1, d, '0, 1'b0);
        end
        @(negedge clk); #2;
        rst = 1'b0; i_valid = 1'b0;
        model_reset();
        #1;
        checks++; if (o_lock !== '0) begin errors++; $display("FAIL midrst_lock got=%h exp=0", o_lock); end
        checks++; if (o_frame_lock !== '0) begin errors++; $display("FAIL midrst_frame_lock got=%h exp=0", o_frame_lock); end
        checks++; if (o_err_pulse !== '0) begin errors++; $display("FAIL midrst_pulse got=%h exp=0", o_err_pulse); end
        checks++; if (o_err_cnt !== '0) begin errors++; $display("FAIL midrst_err_cnt got=%h exp=0", o_err_cnt); end
        checks++; if (o_sync_err_cnt !== '0) begin errors++; $display("FAIL midrst_sync_cnt got=%h exp=0", o_sync_err_cnt); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 65; i++) begin
            gen_clean(d);
            step(1'b1, d, '0, 1'b0);
        end
        checks++; if (o_lock !== '1) begin errors++; $display("FAIL clr_relock got=%h exp=ffff", o_lock); end
        gen_clean(d);
        d[63] = ~d[63]; d[50] = ~d[50]; d[40] = ~d[40];
        step(1'b1, d, '0, 1'b0);
        checks++; if (o_err_cnt[0 +: CW] !== 32'd3) begin errors++; $display("FAIL clr_pre_cnt0 got=%0d exp=3", o_err_cnt[0 +: CW]); end
        gen_clean(d);
        d[62] = ~d[62]; d[45] = ~d[45];
        step(1'b1, d, '0, 1'b1);
        checks++; if (o_err_cnt[0 +: CW] !== 32'd2) begin errors++; $display("FAIL clr_inc_cnt0 got=%0d exp=2", o_err_cnt[0 +: CW]); end
        checks++; if (o_err_pulse !== 16'h0001) begin errors++; $display("FAIL clr_inc_pulse got=%h exp=0001", o_err_pulse); end
        gen_clean(d);
        step(1'b1, d, '0, 1'b1);
        checks++; if (o_err_cnt[0 +: CW] !== 32'd0) begin errors++; $display("FAIL clr_only_cnt0 got=%0d exp=0", o_err_cnt[0 +: CW]); end
    endtask

    task automatic test_random();
        logic [NL*LW-1:0] d;
        logic [NL-1:0]    s;
        logic [NL-1:0]    e_lock, e_fl, e_pulse;
        logic             v, clr;
        for (int t = 0; t < 1200; t++) begin
            v   = (t < 70) ? 1'b1 : ($urandom_range(0, 9) < 8);
            clr = (t >= 70) && ($urandom_range(0, 63) == 0);
            s   = '0;
            if (v) begin
                gen_clean(d);
                for (int l = 0; l < NL; l++) begin
                    if (t >= 70 && $urandom_range(0, 99) == 0) begin
                        int p;
                        p = $urandom_range(0, LW - 1);
                        d[l*LW + p] = ~d[l*LW + p];
                    end
                    if ($urandom_range(0, 39) == 0) s[l] = 1'b1;
                end
            end else begin
                gen_garbage(d);
                s = 16'($urandom);
            end
            step(v, d, s, clr);
            for (int l = 0; l < NL; l++) begin
                e_lock[l] = m_locked[l]; e_fl[l] = m_fl[l]; e_pulse[l] = m_pulse[l];
            end
            checks++; if (o_lock !== e_lock) begin errors++; $display("FAIL rnd_lock_t%0d got=%h exp=%h", t, o_lock, e_lock); end
            checks++; if (o_frame_lock !== e_fl) begin errors++; $display("FAIL rnd_fl_t%0d got=%h exp=%h", t, o_frame_lock, e_fl); end
            checks++; if (o_err_pulse !== e_pulse) begin errors++; $display("FAIL rnd_pulse_t%0d got=%h exp=%h", t, o_err_pulse, e_pulse); end
            for (int l = 0; l < NL; l++) begin
                checks++;
                if (o_err_cnt[l*CW +: CW] !== m_err[l]) begin
                    errors++; $display("FAIL rnd_errcnt_t%0d_l%0d got=%0d exp=%0d", t, l, o_err_cnt[l*CW +: CW], m_err[l]);
                end
                checks++;
                if (o_sync_err_cnt[l*CW +: CW] !== m_serr[l]) begin
                    errors++; $display("FAIL rnd_synccnt_t%0d_l%0d got=%0d exp=%0d", t, l, o_sync_err_cnt[l*CW +: CW], m_serr[l]);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        for (int l = 0; l < NL; l++) begin
            r = $urandom;
            tx_st[l] = r[30:0] | 31'd1;
        end
        model_reset();
        test_reset();
        test_lock();
        test_bit_error();
        test_lane_lockup();
        test_valid_gaps();
        test_sync();
        test_reset_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
